uart_receiver: RTL and testbench

- Serial-to-parallel UART receiver. It is the receive end of the 8N1 link driven by the team's transmitter block.
- Oversamples the line on `bclk`, validates the start bit at mid-bit and shifts data in LSB first.
- Checks the stop bit, then hands the byte to a Receiver Hold Register (RHR) with a ready/read handshake.
- Sits between the external RX pin and the same host logic that drives the transmitter's `d_in`/`load`.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_receiver.sv | 194 +++++++++++++++++++
 tb/tb_uart_receiver.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and receiver FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t c_st_idle   = 3'd0;
  localparam rx_state_t c_st_start  = 3'd1;
  localparam rx_state_t c_st_data   = 3'd2;
  localparam rx_state_t c_st_parity = 3'd3;
  localparam rx_state_t c_st_stop   = 3'd4;
  localparam rx_state_t c_st_break  = 3'd5;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Flop-chain synchroniser for the RX pin; resets to line idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic bclk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge bclk) begin
    if (reset) begin
      r_chain <= {STAGES{IDLE_LEVEL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module      : uart_receiver
// Description : Oversampling 8N1 UART receiver with RHR read handshake and
//               sticky frame/overrun flags. Define UART_RX_PARITY_EN to add
//               an even-parity bit and the parity_err output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       bclk,
  input  logic       reset,
  input  logic       rx_in,
  input  logic       rd,
  input  logic       clr_err,
  output logic [7:0] d_out,
  output logic       rx_status,
  output logic       frame_err,
  output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic [7:0] rx_count
);

  localparam int                  c_TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
  // Start sample lands on the 7th START cycle (OS=16), i.e. mid start bit.
  localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(OVERSAMPLE / 2 - 2);
`ifdef UART_RX_PARITY_EN
  localparam rx_state_t c_st_after_data = c_st_parity;
`else
  localparam rx_state_t c_st_after_data = c_st_stop;
`endif

  logic                 w_rxs;
  rx_state_t            r_state;
  rx_state_t            w_next_state;
  logic [c_TICK_W-1:0]  r_tick;
  logic [2:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rhr;
  logic                 r_status;
  logic                 r_frame_err;
  logic                 r_overrun_err;
  logic [7:0]           r_count;

  logic w_tick_done;
  logic w_data_sample;
  logic w_stop_sample;
  logic w_good;
  logic w_frame_bad;
  logic w_accept;
  logic w_overrun;
  logic w_par_bad;

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .bclk  (bclk),
    .reset (reset),
    .i_d   (rx_in),
    .o_q   (w_rxs)
  );

  always_ff @(posedge bclk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:   if (w_rxs == START_BIT) w_next_state = c_st_start;
      c_st_start:  if (w_tick_done) w_next_state = (w_rxs == START_BIT) ? c_st_data : c_st_idle;
      c_st_data:   if (w_tick_done && (r_bit == 3'd7)) w_next_state = c_st_after_data;
`ifdef UART_RX_PARITY_EN
      c_st_parity: if (w_tick_done) w_next_state = c_st_stop;
`endif
      c_st_stop:   if (w_tick_done) w_next_state = (w_rxs == STOP_BIT) ? c_st_idle : c_st_break;
      // Held-low line must return high before another start can be seen.
      c_st_break:  if (w_rxs == IDLE_LEVEL) w_next_state = c_st_idle;
      default:     w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    w_tick_done = 1'b0;
    case (r_state)
      c_st_start:                       w_tick_done = (r_tick == c_TICK_HALF);
      c_st_data, c_st_parity, c_st_stop: w_tick_done = (r_tick == c_TICK_LAST);
      default:                          w_tick_done = 1'b0;
    endcase
    w_data_sample = (r_state == c_st_data) && w_tick_done;
    w_stop_sample = (r_state == c_st_stop) && w_tick_done;
    w_good        = w_stop_sample && (w_rxs == STOP_BIT) && !w_par_bad;
    w_frame_bad   = w_stop_sample && (w_rxs != STOP_BIT);
    w_accept      = w_good && (!r_status || rd);
    w_overrun     = w_good && r_status && !rd;
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      r_tick        <= '0;
      r_bit         <= 3'd0;
      r_shift       <= '0;
      r_rhr         <= '0;
      r_status      <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
      r_count       <= 8'd0;
    end else begin
      r_tick <= ((w_next_state != r_state) || w_tick_done) ? '0 : r_tick + 1'b1;

      if (r_state == c_st_start) begin
        r_bit <= 3'd0;
      end else if (w_data_sample) begin
        r_bit <= r_bit + 3'd1;
      end

      if (w_data_sample) begin
        r_shift <= {w_rxs, r_shift[DATA_BITS-1:1]};
      end

      if (w_accept) begin
        r_rhr    <= r_shift;
        r_status <= 1'b1;
        r_count  <= r_count + 8'd1;
      end else if (rd && r_status) begin
        r_status <= 1'b0;
      end

      if (w_frame_bad) begin
        r_frame_err <= 1'b1;
      end else if (clr_err) begin
        r_frame_err <= 1'b0;
      end

      if (w_overrun) begin
        r_overrun_err <= 1'b1;
      end else if (clr_err) begin
        r_overrun_err <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;
  logic w_par_sample;

  assign w_par_sample = (r_state == c_st_parity) && w_tick_done;
  assign w_par_bad    = r_par_bad;
  assign parity_err   = r_parity_err;

  always_ff @(posedge bclk) begin
    if (reset) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (r_state == c_st_idle) begin
        r_par_bad <= 1'b0;
      end else if (w_par_sample && (w_rxs != ^r_shift)) begin
        r_par_bad <= 1'b1;
      end

      if (w_par_sample && (w_rxs != ^r_shift)) begin
        r_parity_err <= 1'b1;
      end else if (clr_err) begin
        r_parity_err <= 1'b0;
      end
    end
  end
`else
  assign w_par_bad = 1'b0;
`endif

  assign d_out       = r_rhr;
  assign rx_status   = r_status;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;
  assign rx_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module      : tb_uart_receiver
// Description : Scoreboard bench for uart_receiver: serial frames in, loads
//               checked against a frame-level model by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_receiver;

  localparam int OS   = 16;
  localparam int SYNC = 2;
  // Cycles from driving the start bit to the loaded byte being visible:
  // synchroniser delay plus the middle of the stop bit.
  localparam int LAT  = SYNC + OS / 2 + 9 * OS;

  logic       bclk    = 1'b0;
  logic       reset   = 1'b1;
  logic       rx_in   = 1'b1;
  logic       rd      = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] d_out;
  logic [7:0] rx_count;
  logic       rx_status;
  logic       frame_err;
  logic       overrun_err;

  uart_receiver #(
    .OVERSAMPLE  (OS),
    .SYNC_STAGES (SYNC)
  ) dut (
    .bclk        (bclk),
    .reset       (reset),
    .rx_in       (rx_in),
    .rd          (rd),
    .clr_err     (clr_err),
    .d_out       (d_out),
    .rx_status   (rx_status),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .rx_count    (rx_count)
  );

  always #5 bclk = ~bclk;

  int cyc = 0;
  always @(posedge bclk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         arrive;
    logic [7:0] count;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   resync = 1'b1;

  // Frame-level reference model
  bit         m_pending   = 1'b0;
  logic [7:0] m_count     = 8'd0;
  logic [7:0] m_rhr       = 8'd0;
  bit         m_frame_err = 1'b0;
  bit         m_overrun   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge bclk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input bit rd_at_end,
                            input int nbits, input int tail_low);
    logic [9:0] bits;
    int t0;
    bits = {stop, data, 1'b0};
    @(negedge bclk);
    t0 = cyc;
    if (nbits == 10) begin
      if (stop) begin
        if (!m_pending || rd_at_end) begin
          m_count   = m_count + 8'd1;
          m_rhr     = data;
          m_pending = 1'b1;
          sb.push_back('{data, t0 + LAT, m_count});
        end else begin
          m_overrun = 1'b1;
        end
      end else begin
        m_frame_err = 1'b1;
      end
    end
    for (int k = 0; k < nbits * OS; k++) begin
      if (k > 0) @(negedge bclk);
      rx_in = bits[k / OS];
      rd    = rd_at_end && (k == LAT - 1);
    end
    repeat (tail_low) @(negedge bclk);
    @(negedge bclk);
    rx_in = 1'b1;
    rd    = 1'b0;
  endtask

  task automatic read_rhr();
    @(negedge bclk);
    rd = 1'b1;
    m_pending = 1'b0;
    @(negedge bclk);
    rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge bclk);
    clr_err = 1'b1;
    m_frame_err = 1'b0;
    m_overrun   = 1'b0;
    @(negedge bclk);
    clr_err = 1'b0;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_status"},  rx_status,   m_pending);
    check({tag, "_d_out"},   d_out,       m_rhr);
    check({tag, "_count"},   rx_count,    m_count);
    check({tag, "_frame"},   frame_err,   m_frame_err);
    check({tag, "_overrun"}, overrun_err, m_overrun);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_d_out"},   d_out,       32'h0);
    check({tag, "_status"},  rx_status,   32'h0);
    check({tag, "_frame"},   frame_err,   32'h0);
    check({tag, "_overrun"}, overrun_err, 32'h0);
    check({tag, "_count"},   rx_count,    32'h0);
  endtask

  // Monitor: every rx_count step is a load; pop and compare.
  initial begin : monitor
    logic [7:0] prev;
    exp_t       e;
    prev = 8'd0;
    forever begin
      @(negedge bclk);
      if (resync) begin
        prev = rx_count;
      end else if (rx_count !== prev) begin
        prev = rx_count;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_load: got d_out %0h count %0d, none expected (cycle %0d)",
                   d_out, rx_count, cyc);
        end else begin
          e = sb.pop_front();
          check("load_data",    d_out,     e.data);
          check("load_count",   rx_count,  e.count);
          check("load_latency", cyc,       e.arrive);
          check("load_status",  rx_status, 32'h1);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bit rd_end;
    repeat (3) @(negedge bclk);
    check_reset_values("por");
    reset = 1'b0;
    idle(2);
    resync = 1'b0;

    // Single good frame
    send_frame(8'hA5, 1'b1, 1'b0, 10, 0);
    idle(20);
    check_flags("a5");
    read_rhr();
    idle(2);
    check("a5_read_status", rx_status, 32'h0);
    check("a5_hold_d_out",  d_out,     32'hA5);

    // Short low glitch while idle
    @(negedge bclk);
    rx_in = 1'b0;
    idle(4);
    rx_in = 1'b1;
    idle(40);
    check_flags("glitch");

    // Framing error followed by 40 bit-times of low line
    send_frame(8'h3C, 1'b0, 1'b0, 10, 39 * OS);
    idle(20);
    check_flags("ferr");
    send_frame(8'h11, 1'b1, 1'b0, 10, 0);
    idle(10);
    check_flags("after_ferr");
    read_rhr();
    pulse_clr();
    idle(1);
    check_flags("ferr_clr");

    // Overrun
    send_frame(8'h01, 1'b1, 1'b0, 10, 0);
    idle(5);
    send_frame(8'h02, 1'b1, 1'b0, 10, 0);
    idle(5);
    check_flags("overrun");
    read_rhr();
    idle(1);
    check_flags("overrun_rd");
    pulse_clr();
    idle(1);
    check_flags("overrun_clr");

    // Read in the completion cycle of the next frame
    send_frame(8'h01, 1'b1, 1'b0, 10, 0);
    idle(5);
    send_frame(8'h55, 1'b1, 1'b1, 10, 0);
    idle(5);
    check_flags("rd_at_end");
    read_rhr();

    // Reset in the middle of the data bits
    send_frame(8'hFF, 1'b1, 1'b0, 5, 0);
    resync = 1'b1;
    reset  = 1'b1;
    @(negedge bclk);
    check_reset_values("mid_reset");
    reset = 1'b0;
    m_pending = 1'b0; m_count = 8'd0; m_rhr = 8'd0;
    m_frame_err = 1'b0; m_overrun = 1'b0;
    idle(2);
    resync = 1'b0;
    send_frame(8'h80, 1'b1, 1'b0, 10, 0);
    idle(5);
    check_flags("post_reset");
    read_rhr();

    // Random traffic: 255 more frames wraps rx_count back to 0
    for (int i = 0; i < 255; i++) begin
      rd_end = $urandom_range(0, 1) == 1;
      if (m_pending && !rd_end) read_rhr();
      send_frame(8'($urandom), 1'b1, rd_end, 10, 0);
      idle($urandom_range(0, 12));
      if (!rd_end) read_rhr();
    end
    idle(5);
    check_flags("wrap");
    check("wrap_count", rx_count, m_count);
    check("sb_empty", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
